i2f32_arb: RTL

// - Round-robin arbiter/sequencer sharing one i2f32 integer-to-float converter among NREQ requesters.
// - Grants at most one conversion per enabled cycle and steers that requester's op/rm/i to the converter.
// - Tracks the granted requester through the converter's 1-cycle latency and returns the result with a one-hot done.
// - Sits between integer-issue ports (e.g. per-thread ALU slots) and a single shared i2f32 instance.

---
 rtl/i2f32_arb_if.sv | 35 +++
 rtl/i2f32_arb.sv | 91 +++++++++
 2 files changed

// File: rtl/i2f32_arb_if.sv
// Bundle of the requester-side and converter-side signals of the shared
// i2f32 arbiter. The arbiter connects through the slave modport. Whatever
// drives the requesters and models the converter connects through master.
//
// Handshake: req[k] is a valid that is held, together with op/rm/i of slot k,
// until ack[k] pulses. ack[k] is the ready and fires for one cycle when the
// operands are consumed. done[k] is a one-cycle result-valid with no ready:
// the requester must take o in that cycle.
interface i2f32_arb_if #(
  parameter int NREQ  = 4,
  parameter int FPWID = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       op;
  logic [3*NREQ-1:0]     rm;
  logic [FPWID*NREQ-1:0] i;
  logic [NREQ-1:0]       ack;
  logic                  cv_op;
  logic [2:0]            cv_rm;
  logic [FPWID-1:0]      cv_i;
  logic [FPWID-1:0]      cv_o;
  logic [NREQ-1:0]       done;
  logic [FPWID-1:0]      o;
  logic                  busy;

  modport slave (
    input  req, op, rm, i, cv_o,
    output ack, cv_op, cv_rm, cv_i, done, o, busy
  );

  modport master (
    output req, op, rm, i, cv_o,
    input  ack, cv_op, cv_rm, cv_i, done, o, busy
  );
endinterface

// File: rtl/i2f32_arb.sv
// Round-robin sequencer that shares one i2f32 converter, which has a latency of
// one cycle, among NREQ requesters. The arbiter grants at most one conversion on
// each enabled cycle and routes the operands of the winner to the converter. It
// remembers the winner for one enabled cycle and then returns the converter
// result to that requester with a one-hot done.
module i2f32_arb #(
  parameter int NREQ  = 4,
  parameter int FPWID = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  i2f32_arb_if.slave      bus
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [TW-1:0] ptr_q;
  logic [TW-1:0] tag_q;
  logic          vld_q;

  logic          gnt_any;
  logic [TW-1:0] gnt_idx;
  logic          gnt_fire;
  logic [TW-1:0] sel;
  logic [TW:0]   cand;
  logic [TW:0]   ptr_nxt;

  // Search for the first request, starting at ptr_q and wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, ptr_q} + (TW+1)'(j);
      if (cand >= (TW+1)'(NREQ)) cand = cand - (TW+1)'(NREQ);
      if (!gnt_any && bus.req[cand[TW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[TW-1:0];
      end
    end
  end

  // A grant counts only on a live, enabled cycle. With no grant the mux
  // follows ptr_q, which keeps the converter inputs stable.
  always_comb begin
    gnt_fire = gnt_any & ce & rst_n;
    sel      = gnt_fire ? gnt_idx : ptr_q;
    ptr_nxt  = {1'b0, gnt_idx} + (TW+1)'(1);
    if (ptr_nxt >= (TW+1)'(NREQ)) ptr_nxt = '0;
  end

  // One-hot ack for the winner.
  always_comb begin
    bus.ack = '0;
    if (gnt_fire) bus.ack[gnt_idx] = 1'b1;
  end

  // One-hot done for the conversion in flight. It is masked during reset so
  // that a dropped conversion never surfaces.
  always_comb begin
    bus.done = '0;
    if (vld_q && ce && rst_n) bus.done[tag_q] = 1'b1;
  end

  // Steer the operands of the selected requester to the shared converter.
  always_comb begin
    bus.cv_op = bus.op[sel];
    bus.cv_rm = bus.rm[3*int'(sel) +: 3];
    bus.cv_i  = bus.i[FPWID*int'(sel) +: FPWID];
    bus.o     = bus.cv_o;
    bus.busy  = vld_q;
  end

  // Pointer and in-flight tracking. This state freezes together with the
  // converter whenever ce is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      tag_q <= '0;
      vld_q <= 1'b0;
    end else if (ce) begin
      vld_q <= gnt_fire;
      if (gnt_fire) begin
        tag_q <= gnt_idx;
        ptr_q <= ptr_nxt[TW-1:0];
      end
    end
  end

endmodule
